// File: rtl/segasys1_pkg.sv
// Shared types and constants for the Sega System 1 download controller.
package segasys1_pkg;

    // Download controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } dl_state_t;

    // ioctl_index targets understood by the controller
    localparam logic [7:0] IDX_ROM     = 8'd0;
    localparam logic [7:0] IDX_SYSMODE = 8'd1;
    localparam logic [7:0] IDX_DSW     = 8'd254;

    // Power-on value of the DIP switch bank (all switches off)
    localparam logic [63:0] DSW_DEFAULT = {8{8'hFF}};

endpackage

// File: rtl/segasys1_dl_ctrl.sv
// Download controller: routes ioctl bytes to the game ROM port, sysmode
// and DIP registers, and sequences the game-core reset around ROM loads.
module segasys1_dl_ctrl
    import segasys1_pkg::*;
#(
    parameter logic [24:0] ROM_SIZE = 25'h0100000,
    parameter int          RST_HOLD = 1024
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [24:0] rom_ad,
    output logic [7:0]  rom_dt,
    output logic        rom_en,
    output logic [7:0]  sysmode,
    output logic [63:0] dsw,
    output logic        core_reset,
    output logic        rom_loaded,
    output logic        rom_ovf
);

    localparam logic [15:0] SETTLE_LAST = 16'(RST_HOLD - 1);

    dl_state_t   state;
    dl_state_t   state_next;
    logic        dl_q;
    logic [24:0] byte_cnt;
    logic [15:0] settle_cnt;

    logic        dl_rise;
    logic        dl_fall;
    logic        rom_start;
    logic        rom_strobe;
    logic        rom_accept;
    logic        rom_reject;
    logic        settle_done;
    logic        sysmode_wr;
    logic        dsw_wr;

    // The falling-edge cycle still belongs to the session, so a strobe that
    // lands on it is treated as part of the ROM image.
    assign dl_rise     = ioctl_download & ~dl_q;
    assign dl_fall     = ~ioctl_download & dl_q;
    assign rom_start   = dl_rise && (ioctl_index == IDX_ROM);
    assign rom_strobe  = (state == LOAD) && ioctl_wr && (ioctl_index == IDX_ROM)
                         && (ioctl_download || dl_q);
    assign rom_accept  = rom_strobe && (ioctl_addr < ROM_SIZE);
    assign rom_reject  = rom_strobe && (ioctl_addr >= ROM_SIZE);
    assign settle_done = (state == SETTLE) && (settle_cnt == SETTLE_LAST);
    assign sysmode_wr  = ioctl_wr && ioctl_download && (ioctl_index == IDX_SYSMODE)
                         && (ioctl_addr == 25'd0);
    assign dsw_wr      = ioctl_wr && ioctl_download && (ioctl_index == IDX_DSW)
                         && (ioctl_addr < 25'd8);

    // Download edge detector; resets low so a session already open at reset
    // release is seen as a fresh start.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) dl_q <= 1'b0;
        else       dl_q <= ioctl_download;
    end

    // State register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; a new ROM session pre-empts whatever is in progress
    always_comb begin
        state_next = state;
        if (rom_start) begin
            state_next = LOAD;
        end else begin
            case (state)
                LOAD: begin
                    if (dl_fall) begin
                        if ((byte_cnt != 25'd0) || rom_accept) state_next = SETTLE;
                        else                                   state_next = IDLE;
                    end
                end
                SETTLE: begin
                    if (settle_done) state_next = RUN;
                end
                default: state_next = state;
            endcase
        end
    end

    // Count of ROM bytes accepted in the current session
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)           byte_cnt <= 25'd0;
        else if (rom_start)  byte_cnt <= 25'd0;
        else if (rom_accept) byte_cnt <= byte_cnt + 25'd1;
    end

    // Settle timer runs only while in SETTLE and restarts on every entry
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)                settle_cnt <= 16'd0;
        else if (state != SETTLE) settle_cnt <= 16'd0;
        else                      settle_cnt <= settle_cnt + 16'd1;
    end

    // Registered ROM write port towards the game core
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rom_en <= 1'b0;
            rom_ad <= 25'd0;
            rom_dt <= 8'd0;
        end else begin
            rom_en <= rom_accept;
            if (rom_accept) begin
                rom_ad <= ioctl_addr;
                rom_dt <= ioctl_dout;
            end
        end
    end

    // Core reset follows the upcoming state so it drops together with RUN
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) core_reset <= 1'b1;
        else       core_reset <= (state_next != RUN);
    end

    // ROM status flags: both cleared at session start, loaded set on entry to RUN
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rom_loaded <= 1'b0;
            rom_ovf    <= 1'b0;
        end else if (rom_start) begin
            rom_loaded <= 1'b0;
            rom_ovf    <= 1'b0;
        end else begin
            if (settle_done) rom_loaded <= 1'b1;
            if (rom_reject)  rom_ovf    <= 1'b1;
        end
    end

    // Configuration registers writable at any time during their own session
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sysmode <= 8'h00;
            dsw     <= DSW_DEFAULT;
        end else begin
            if (sysmode_wr) sysmode <= ioctl_dout;
            if (dsw_wr)     dsw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
        end
    end

endmodule

// File: tb/tb_segasys1_dl_ctrl.sv
// Directed self-checking bench for segasys1_dl_ctrl with a ROM write scoreboard.
module tb_segasys1_dl_ctrl;

    localparam logic [24:0] ROM_SIZE = 25'h0100000;
    localparam int          RST_HOLD = 16;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic [24:0] rom_ad;
    logic [7:0]  rom_dt;
    logic        rom_en;
    logic [7:0]  sysmode;
    logic [63:0] dsw;
    logic        core_reset;
    logic        rom_loaded;
    logic        rom_ovf;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [24:0] a;
        logic [7:0]  d;
    } rom_wr_t;

    rom_wr_t exp_q[$];

    segasys1_dl_ctrl #(.ROM_SIZE(ROM_SIZE), .RST_HOLD(RST_HOLD)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .rom_ad         (rom_ad),
        .rom_dt         (rom_dt),
        .rom_en         (rom_en),
        .sysmode        (sysmode),
        .dsw            (dsw),
        .core_reset     (core_reset),
        .rom_loaded     (rom_loaded),
        .rom_ovf        (rom_ovf)
    );

    // Free-running system clock
    always #5 clk_sys = ~clk_sys;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic applyStimulus(input logic dl, input logic wr, input logic [7:0] idx,
                                 input logic [24:0] addr, input logic [7:0] dout);
        ioctl_download = dl;
        ioctl_wr       = wr;
        ioctl_index    = idx;
        ioctl_addr     = addr;
        ioctl_dout     = dout;
    endtask

    // One-cycle ROM strobe; expect a single rom_en pulse when the address is in range
    task automatic romWrite(input logic [24:0] addr, input logic [7:0] data, input logic expect_en);
        if (expect_en) exp_q.push_back('{a: addr, d: data});
        applyStimulus(1'b1, 1'b1, 8'd0, addr, data);
        tick();
        checkOutput("rom_en_after_strobe", rom_en, expect_en);
        applyStimulus(1'b1, 1'b0, 8'd0, addr, data);
        tick();
        checkOutput("rom_en_one_cycle", rom_en, 1'b0);
    endtask

    // Config byte write within an already open session of index idx
    task automatic cfgWrite(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
        applyStimulus(1'b1, 1'b1, idx, addr, data);
        tick();
        applyStimulus(1'b1, 1'b0, idx, addr, data);
        tick();
    endtask

    // Scoreboard: every rom_en pulse must match the oldest expected write
    always @(negedge clk_sys) begin : rom_monitor
        rom_wr_t e;
        if (rom_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("rom_en_unexpected", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("rom_write", {rom_ad, rom_dt}, {e.a, e.d});
            end
        end
    end

    // Global time limit
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic saw_low;

        // Reset values while reset is held
        #23;
        checkOutput("rst_core_reset", core_reset, 1'b1);
        checkOutput("rst_rom_en", rom_en, 1'b0);
        checkOutput("rst_rom_ad", rom_ad, 25'd0);
        checkOutput("rst_rom_dt", rom_dt, 8'd0);
        checkOutput("rst_rom_loaded", rom_loaded, 1'b0);
        checkOutput("rst_rom_ovf", rom_ovf, 1'b0);
        checkOutput("rst_sysmode", sysmode, 8'h00);
        checkOutput("rst_dsw", dsw, {8{8'hFF}});
        tick();
        reset = 1'b0;
        tick();
        tick();
        checkOutput("idle_core_reset", core_reset, 1'b1);

        // ROM load of four bytes, then settle into RUN
        applyStimulus(1'b1, 1'b0, 8'd0, 25'd0, 8'd0);
        tick();
        for (int i = 0; i < 4; i++) romWrite(25'(i), 8'hA0 + 8'(i), 1'b1);
        applyStimulus(1'b0, 1'b0, 8'd0, 25'd0, 8'd0);
        n = 0;
        while (core_reset !== 1'b0 && n < RST_HOLD + 10) begin
            tick();
            n++;
        end
        checkOutput("settle_length", 64'(n), 64'(RST_HOLD + 1));
        checkOutput("run_rom_loaded", rom_loaded, 1'b1);

        // DIP switches in RUN, including an out-of-range address
        applyStimulus(1'b1, 1'b0, 8'd254, 25'd0, 8'd0);
        tick();
        for (int i = 0; i < 9; i++) cfgWrite(8'd254, 25'(i), (i == 8) ? 8'h55 : 8'(i));
        applyStimulus(1'b0, 1'b0, 8'd254, 25'd0, 8'd0);
        tick();
        checkOutput("dsw_bytes", dsw, 64'h0706050403020100);
        checkOutput("dsw_core_reset", core_reset, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd254, 25'd0, 8'hAA);
        tick();
        applyStimulus(1'b0, 1'b0, 8'd254, 25'd0, 8'hAA);
        tick();
        checkOutput("dsw_no_session", dsw, 64'h0706050403020100);

        // Sysmode: only address 0 counts
        applyStimulus(1'b1, 1'b0, 8'd1, 25'd0, 8'd0);
        tick();
        cfgWrite(8'd1, 25'd0, 8'h06);
        cfgWrite(8'd1, 25'd1, 8'h77);
        applyStimulus(1'b0, 1'b0, 8'd1, 25'd0, 8'd0);
        tick();
        checkOutput("sysmode_value", sysmode, 8'h06);
        checkOutput("sysmode_core_reset", core_reset, 1'b0);

        // Unknown index is ignored entirely
        applyStimulus(1'b1, 1'b0, 8'd2, 25'd0, 8'd0);
        tick();
        cfgWrite(8'd2, 25'd0, 8'h33);
        applyStimulus(1'b0, 1'b0, 8'd2, 25'd0, 8'd0);
        tick();
        checkOutput("idx2_sysmode", sysmode, 8'h06);
        checkOutput("idx2_core_reset", core_reset, 1'b0);
        checkOutput("idx2_rom_loaded", rom_loaded, 1'b1);

        // Overflow write during a new load
        applyStimulus(1'b1, 1'b0, 8'd0, 25'd0, 8'd0);
        tick();
        checkOutput("reload_rom_loaded", rom_loaded, 1'b0);
        checkOutput("reload_core_reset", core_reset, 1'b1);
        romWrite(ROM_SIZE, 8'h5A, 1'b0);
        checkOutput("ovf_set", rom_ovf, 1'b1);
        romWrite(ROM_SIZE - 25'd1, 8'hC3, 1'b1);
        checkOutput("ovf_sticky", rom_ovf, 1'b1);

        // Restart at cycle 10 of SETTLE, then close an empty session
        applyStimulus(1'b0, 1'b0, 8'd0, 25'd0, 8'd0);
        tick();
        for (int i = 0; i < 9; i++) tick();
        applyStimulus(1'b1, 1'b0, 8'd0, 25'd0, 8'd0);
        tick();
        checkOutput("restart_ovf_cleared", rom_ovf, 1'b0);
        checkOutput("restart_rom_loaded", rom_loaded, 1'b0);
        checkOutput("restart_core_reset", core_reset, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'd0, 25'd0, 8'd0);
        saw_low = 1'b0;
        for (int i = 0; i < RST_HOLD + 5; i++) begin
            tick();
            if (core_reset !== 1'b1) saw_low = 1'b1;
        end
        checkOutput("empty_stays_reset", saw_low, 1'b0);
        checkOutput("empty_rom_loaded", rom_loaded, 1'b0);

        // Asynchronous reset between edges while a write is on the ROM port
        applyStimulus(1'b1, 1'b0, 8'd0, 25'd0, 8'd0);
        tick();
        applyStimulus(1'b1, 1'b1, 8'd0, 25'h10, 8'hEE);
        @(posedge clk_sys);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_rom_en", rom_en, 1'b0);
        checkOutput("async_rom_ad", rom_ad, 25'd0);
        checkOutput("async_rom_dt", rom_dt, 8'd0);
        checkOutput("async_core_reset", core_reset, 1'b1);
        checkOutput("async_sysmode", sysmode, 8'h00);
        checkOutput("async_dsw", dsw, {8{8'hFF}});
        applyStimulus(1'b0, 1'b0, 8'd0, 25'd0, 8'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checkOutput("post_reset_idle", core_reset, 1'b1);
        checkOutput("post_reset_rom_en", rom_en, 1'b0);

        // Session already open at reset release counts as a start
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'd0, 25'd0, 8'd0);
        tick();
        reset = 1'b0;
        tick();
        romWrite(25'd7, 8'h42, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'd0, 25'd0, 8'd0);
        n = 0;
        while (core_reset !== 1'b0 && n < RST_HOLD + 10) begin
            tick();
            n++;
        end
        checkOutput("held_dl_settle", 64'(n), 64'(RST_HOLD + 1));
        checkOutput("held_dl_loaded", rom_loaded, 1'b1);

        tick();
        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
